bcd_step_counter_0_2: RTL and testbench

BCD_STEP_COUNTER_0_2 -- requirements
Module: bcd_step_counter_0_2

---
 rtl/bcd_step_counter_0_2_pkg.sv | 15 +
 rtl/bcd_step_counter_0_2_if.sv | 23 ++
 rtl/bcd_step_counter_0_2_key_debouncer.sv | 88 ++++++++
 rtl/bcd_step_counter_0_2.sv | 83 ++++++++
 tb/tb_bcd_step_counter_0_2.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_step_counter_0_2_pkg.sv
// Shared types and constants for the 0..2 BCD step counter and its key debouncers.
package bcd_step_counter_0_2_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } deb_state_e;

    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd2;

endpackage

// File: rtl/bcd_step_counter_0_2_if.sv
// Key inputs, enable and count outputs of the 0..2 BCD step counter.
interface bcd_step_counter_0_2_if;
    import bcd_step_counter_0_2_pkg::*;

    logic             key_up_n;
    logic             key_down_n;
    logic             enable;
    logic [BCD_W-1:0] bcd;
    logic             step_pulse;
    logic             at_min;
    logic             at_max;

    modport master (
        output key_up_n, key_down_n, enable,
        input  bcd, step_pulse, at_min, at_max
    );

    modport slave (
        input  key_up_n, key_down_n, enable,
        output bcd, step_pulse, at_min, at_max
    );

endinterface

// File: rtl/bcd_step_counter_0_2_key_debouncer.sv
// 2-flop synchronizer + debounce FSM; one press_o strobe per qualified physical press.
// Strobe rises DEBOUNCE_CYCLES+3 edges after the raw key is stably low; no backpressure.
module key_debouncer
    import bcd_step_counter_0_2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             key_act;
    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign key_act = ~sync2_q;

    // The IDLE sample only arms the FSM; qualification counts samples taken in WAIT_PRESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (key_act) begin
                        state_q <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (!key_act) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    state_q <= WAIT_RELEASE;
                    cnt_q   <= '0;
                end
                WAIT_RELEASE: begin
                    if (key_act) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/bcd_step_counter_0_2.sv
// Debounced up/down BCD counter over 0..2 with wrap or saturate at the ends.
// bcd/step_pulse update the edge after a press strobe (DEBOUNCE_CYCLES+4 edges); no backpressure.
module bcd_step_counter_0_2
    import bcd_step_counter_0_2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit WRAP            = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    bcd_step_counter_0_2_if.slave   bus
);

    localparam logic [BCD_W-1:0] BCD_ONE = BCD_W'(1);

    logic             up_stb;
    logic             dn_stb;
    logic             up_go;
    logic             dn_go;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_d;
    logic             step_q;
    logic             step_d;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_deb (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (bus.key_up_n),
        .press_o (up_stb)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_deb (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (bus.key_down_n),
        .press_o (dn_stb)
    );

    // Coincident strobes cancel; disabled strobes are simply dropped.
    assign up_go = up_stb & ~dn_stb & bus.enable;
    assign dn_go = dn_stb & ~up_stb & bus.enable;

    always_comb begin
        bcd_d  = bcd_q;
        step_d = 1'b0;
        if (up_go) begin
            if (bcd_q < BCD_MAX) begin
                bcd_d  = bcd_q + BCD_ONE;
                step_d = 1'b1;
            end else if (WRAP) begin
                bcd_d  = BCD_MIN;
                step_d = 1'b1;
            end
        end else if (dn_go) begin
            if (bcd_q > BCD_MAX) begin
                bcd_d  = BCD_MIN;
                step_d = 1'b1;
            end else if (bcd_q != BCD_MIN) begin
                bcd_d  = bcd_q - BCD_ONE;
                step_d = 1'b1;
            end else if (WRAP) begin
                bcd_d  = BCD_MAX;
                step_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q  <= BCD_MIN;
            step_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            step_q <= step_d;
        end
    end

    assign bus.bcd        = bcd_q;
    assign bus.step_pulse = step_q;
    assign bus.at_min     = (bcd_q == BCD_MIN);
    assign bus.at_max     = (bcd_q == BCD_MAX);

endmodule

// File: tb/tb_bcd_step_counter_0_2.sv
// Directed bench: a WRAP=1 and a WRAP=0 counter driven by the same keys, checked against hand-computed tables.
module tb_bcd_step_counter_0_2;
    import bcd_step_counter_0_2_pkg::*;

    localparam int DEB      = 4;
    localparam int HOLD     = 20;
    localparam int REL_WAIT = 12;
    localparam int NV       = 10;
    localparam int A_UP     = 1;
    localparam int A_DN     = 2;
    localparam int A_BOTH   = 3;

    logic clk = 1'b0;
    logic reset;
    logic key_up_n;
    logic key_down_n;
    logic enable;

    always #5 clk = ~clk;

    bcd_step_counter_0_2_if w1_if ();
    bcd_step_counter_0_2_if w0_if ();

    assign w1_if.key_up_n   = key_up_n;
    assign w1_if.key_down_n = key_down_n;
    assign w1_if.enable     = enable;
    assign w0_if.key_up_n   = key_up_n;
    assign w0_if.key_down_n = key_down_n;
    assign w0_if.enable     = enable;

    bcd_step_counter_0_2 #(.DEBOUNCE_CYCLES(DEB), .WRAP(1'b1)) dut_w1 (
        .clk   (clk),
        .reset (reset),
        .bus   (w1_if)
    );

    bcd_step_counter_0_2 #(.DEBOUNCE_CYCLES(DEB), .WRAP(1'b0)) dut_w0 (
        .clk   (clk),
        .reset (reset),
        .bus   (w0_if)
    );

    typedef struct {
        int act;
        bit en_start;
        bit en_mid;
        int w1_bcd;
        int w1_pulses;
        int w0_bcd;
        int w0_pulses;
    } vec_t;

    vec_t vecs [NV];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   p1     = 0;
    int   p0     = 0;

    // step_pulse sampled at the edge that ends its cycle, so each pulse counts once.
    always @(posedge clk) begin
        if (w1_if.step_pulse === 1'b1) p1 = p1 + 1;
        if (w0_if.step_pulse === 1'b1) p0 = p0 + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input int act, input bit en_start, input bit en_mid);
        @(negedge clk);
        enable = en_start;
        if (act[0]) key_up_n = 1'b0;
        if (act[1]) key_down_n = 1'b0;
        repeat (HOLD / 2) @(negedge clk);
        enable = en_mid;
        repeat (HOLD / 2) @(negedge clk);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (REL_WAIT) @(negedge clk);
        enable = 1'b1;
    endtask

    initial begin
        int s1;
        int s0;
        int first;

        //           act     en0   en1   w1 bcd/p  w0 bcd/p
        vecs[0] = '{A_UP,   1'b1, 1'b1, 2, 1, 2, 1};
        vecs[1] = '{A_UP,   1'b1, 1'b1, 0, 1, 2, 0};
        vecs[2] = '{A_DN,   1'b1, 1'b1, 2, 1, 1, 1};
        vecs[3] = '{A_BOTH, 1'b1, 1'b1, 2, 0, 1, 0};
        vecs[4] = '{A_UP,   1'b0, 1'b0, 2, 0, 1, 0};
        vecs[5] = '{A_DN,   1'b0, 1'b1, 2, 0, 1, 0};
        vecs[6] = '{A_DN,   1'b1, 1'b1, 1, 1, 0, 1};
        vecs[7] = '{A_DN,   1'b1, 1'b1, 0, 1, 0, 0};
        vecs[8] = '{A_UP,   1'b1, 1'b1, 1, 1, 1, 1};
        vecs[9] = '{A_UP,   1'b1, 1'b1, 2, 1, 2, 1};

        reset      = 1'b1;
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        enable     = 1'b1;
        repeat (2) @(negedge clk);
        check("reset bcd",    int'(w1_if.bcd),        0);
        check("reset step",   int'(w1_if.step_pulse), 0);
        check("reset at_min", int'(w1_if.at_min),     1);
        check("reset at_max", int'(w1_if.at_max),     0);
        check("reset w0 bcd", int'(w0_if.bcd),        0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Bouncy up press: only the stable-low tail may qualify, 8 edges after it begins.
        s1 = p1;
        for (int b = 0; b < 3; b++) begin
            key_up_n = 1'b0;
            repeat (2) @(negedge clk);
            key_up_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        key_up_n = 1'b0;
        first    = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 7) begin
                check("bounce bcd before step",    int'(w1_if.bcd),    0);
                check("bounce at_min before step", int'(w1_if.at_min), 1);
            end
            if (w1_if.step_pulse === 1'b1 && first < 0) begin
                first = k;
                check("bounce bcd at step",    int'(w1_if.bcd),    1);
                check("bounce at_min at step", int'(w1_if.at_min), 0);
            end
        end
        check("bounce step edge", first, 8);
        repeat (10) @(negedge clk);
        key_up_n = 1'b1;
        repeat (REL_WAIT) @(negedge clk);
        check("bounce w1 pulses", p1 - s1,         1);
        check("bounce w1 bcd",    int'(w1_if.bcd), 1);
        check("bounce w0 bcd",    int'(w0_if.bcd), 1);

        for (int i = 0; i < NV; i++) begin
            s1 = p1;
            s0 = p0;
            press(vecs[i].act, vecs[i].en_start, vecs[i].en_mid);
            check($sformatf("v%0d w1 bcd", i),    int'(w1_if.bcd),    vecs[i].w1_bcd);
            check($sformatf("v%0d w1 pulses", i), p1 - s1,            vecs[i].w1_pulses);
            check($sformatf("v%0d w1 at_min", i), int'(w1_if.at_min), int'(vecs[i].w1_bcd == 0));
            check($sformatf("v%0d w1 at_max", i), int'(w1_if.at_max), int'(vecs[i].w1_bcd == 2));
            check($sformatf("v%0d w0 bcd", i),    int'(w0_if.bcd),    vecs[i].w0_bcd);
            check($sformatf("v%0d w0 pulses", i), p0 - s0,            vecs[i].w0_pulses);
        end

        // Reset while key_down is mid-qualification, then requalify the still-held key.
        @(negedge clk);
        key_down_n = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset w1 bcd", int'(w1_if.bcd), 2);
        #2 reset = 1'b1;
        #1;
        check("async reset w1 bcd",    int'(w1_if.bcd),        0);
        check("async reset w1 at_min", int'(w1_if.at_min),     1);
        check("async reset w1 at_max", int'(w1_if.at_max),     0);
        check("async reset w1 step",   int'(w1_if.step_pulse), 0);
        check("async reset w0 bcd",    int'(w0_if.bcd),        0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        s1    = p1;
        s0    = p0;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (w1_if.step_pulse === 1'b1 && first < 0) first = k;
        end
        check("post-reset step edge", first, 8);
        repeat (8) @(negedge clk);
        key_down_n = 1'b1;
        repeat (REL_WAIT) @(negedge clk);
        check("post-reset w1 pulses", p1 - s1,            1);
        check("post-reset w1 bcd",    int'(w1_if.bcd),    2);
        check("post-reset w1 at_max", int'(w1_if.at_max), 1);
        check("post-reset w0 pulses", p0 - s0,            0);
        check("post-reset w0 bcd",    int'(w0_if.bcd),    0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
